// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//
// Hunts a serial line for a programmable, maskable start pattern. On a hit it
// wakes the n-bit receiver, waits for the transmitter to report ready, wakes
// the transmitter, then waits for the end-of-transaction return before hunting
// again. Each wait state can time out, which sets a sticky error flag.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   synchronous, active-low reset
//   serial_in           in   serial data, one bit per clock, MSB of pattern first
//   transmitter_signal  in   transmitter ready (level), only looked at in WAIT_TR
//   get_back            in   transaction done (level), only looked at in WAIT_BACK
//   clr_err             in   clears timeout_err (a simultaneous timeout wins)
//   wake_nbit           out  one-cycle pulse, starts on the edge sampling the last pattern bit
//   wake_transmitter    out  one-cycle pulse, starts on the edge sampling transmitter_signal=1
//   busy                out  high whenever not hunting
//   timeout_err         out  sticky timeout flag
//   match_count         out  detections so far, wraps modulo 2^CNT_W
//
// Handshake: transmitter_signal and get_back are levels, not pulses. A wait
// state completes on the first edge at which its own input is high (including
// the very first cycle in that state); each input is ignored in every other
// state, so a level left high from an earlier phase cannot skip a step.

module pattern_sequencer #(
  parameter int                 PAT_LEN = 7,
  parameter logic [PAT_LEN-1:0] PATTERN = 7'b0111110,
  parameter logic [PAT_LEN-1:0] MASK    = {PAT_LEN{1'b1}},
  parameter int                 TIMEOUT = 0,
  parameter int                 TO_W    = 8,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             transmitter_signal,
  input  logic             get_back,
  input  logic             clr_err,
  output logic             wake_nbit,
  output logic             wake_transmitter,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] match_count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam bit                TO_EN     = (TIMEOUT != 0);
  // Last tcnt value before a timeout fires; meaningless (and unused) when TO_EN is 0.
  localparam logic [TO_W-1:0]   TO_LAST   = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    HUNT      = 3'd0,
    RISE_NBIT = 3'd1,
    WAIT_TR   = 3'd2,
    RISE_TR   = 3'd3,
    WAIT_BACK = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_LEN-1:0]  sh_q, sh_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wake_nbit_q, wake_nbit_d;
  logic                wake_tr_q, wake_tr_d;
  logic                busy_q, busy_d;
  logic                timeout_hit;

  // The match looks at the window as it will be after this edge, so the wake
  // pulse lines up with the edge that samples the final pattern bit.
  logic [PAT_LEN-1:0]  sh_next;
  logic [FILL_W-1:0]   fill_next;
  logic                match;

  assign sh_next   = {sh_q[PAT_LEN-2:0], serial_in};
  assign fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign match     = (fill_next == FILL_FULL) && (((sh_next ^ PATTERN) & MASK) == '0);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    fill_d      = fill_q;
    tcnt_d      = tcnt_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;

    case (state_q)
      HUNT: begin
        if (match) begin
          // Leaving HUNT: forget the window so the next detection needs a full fresh pattern.
          state_d = RISE_NBIT;
          sh_d    = '0;
          fill_d  = '0;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          sh_d   = sh_next;
          fill_d = fill_next;
        end
      end
      RISE_NBIT: begin
        state_d = WAIT_TR;
        tcnt_d  = '0;
      end
      WAIT_TR: begin
        // The ready signal beats a terminal count on the same edge.
        if (transmitter_signal) begin
          state_d = RISE_TR;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          state_d     = HUNT;
          timeout_hit = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RISE_TR: begin
        state_d = WAIT_BACK;
        tcnt_d  = '0;
      end
      WAIT_BACK: begin
        if (get_back) begin
          state_d = HUNT;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          state_d     = HUNT;
          timeout_hit = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        sh_d    = '0;
        fill_d  = '0;
      end
    endcase

    // A timeout on the same edge as a clear leaves the flag set.
    err_d = timeout_hit | (err_q & ~clr_err);

    // Outputs are decoded from the next state so they are flops aligned with the state.
    wake_nbit_d = (state_d == RISE_NBIT);
    wake_tr_d   = (state_d == RISE_TR);
    busy_d      = (state_d != HUNT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      sh_q        <= '0;
      fill_q      <= '0;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wake_nbit_q <= 1'b0;
      wake_tr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      fill_q      <= fill_d;
      tcnt_q      <= tcnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wake_nbit_q <= wake_nbit_d;
      wake_tr_q   <= wake_tr_d;
      busy_q      <= busy_d;
    end
  end

  assign wake_nbit        = wake_nbit_q;
  assign wake_transmitter = wake_tr_q;
  assign busy             = busy_q;
  assign timeout_err      = err_q;
  assign match_count      = cnt_q;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised successor of the fixed 7-bit serial start-pattern detector/sequencer.
- Detects a programmable, maskable serial pattern of length PAT_LEN, then runs the handshake wake n-bit receiver -> wait transmitter ready -> wake transmitter -> wait get_back.
- Adds timeouts with a sticky error flag, a detection counter and a busy indicator.
- Sits between the serial line front-end and the n-bit receiver/transmitter blocks.

Parameters:
- PAT_LEN, 7, pattern length in bits (2..16).
- PATTERN, 7'b0111110, expected pattern; bit PAT_LEN-1 is received first.
- MASK, all ones (PAT_LEN bits), 1 = bit compared, 0 = don't-care.
- TIMEOUT, 0, max wait cycles in each wait state; 0 = no timeout (wait forever).
- TO_W, 8, width of timeout counter; TIMEOUT must be < 2^TO_W.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- serial_in  input  1  serial data, sampled every clk.
- transmitter_signal  input  1  transmitter ready, level.
- get_back  input  1  end-of-transaction return, level.
- clr_err  input  1  clears timeout_err.
- wake_nbit  output  1  one-cycle pulse after pattern detected.
- wake_transmitter  output  1  one-cycle pulse after transmitter_signal seen.
- busy  output  1  high in every state except HUNT.
- timeout_err  output  1  sticky, set on any wait timeout.
- match_count  output  CNT_W  number of detections, wraps modulo 2^CNT_W.

Behaviour:
- Reset: rst low at a rising edge -> state HUNT, shift register 0, fill counter 0, timeout counter 0, all outputs 0, match_count 0. Reset takes priority in every state, mid-handshake included.
- Shift register sh[PAT_LEN-1:0]: in HUNT, every edge sh <= {sh[PAT_LEN-2:0], serial_in}. fill increments, saturating at PAT_LEN.
- Match is combinational on the next sh value: fill_next == PAT_LEN and ((sh_next ^ PATTERN) & MASK) == 0. A partial fill never matches.
- States and transitions:
  - HUNT: match -> RISE_NBIT, else stay.
  - RISE_NBIT: always -> WAIT_TR.
  - WAIT_TR: transmitter_signal=1 -> RISE_TR. Else, if TIMEOUT != 0 and tcnt == TIMEOUT-1 -> HUNT with timeout_err set. Else stay and tcnt++.
  - RISE_TR: always -> WAIT_BACK.
  - WAIT_BACK: same as WAIT_TR, with get_back as the signal and HUNT as the success target.
- tcnt clears on every entry to WAIT_TR and WAIT_BACK.
- If the signal arrives on the same cycle as terminal count, the signal wins and no error is raised.
- Outputs are registered and decoded from the current state:
  - wake_nbit = (state == RISE_NBIT).
  - wake_transmitter = (state == RISE_TR).
  - busy = (state != HUNT).
- Latency:
  - wake_nbit is high exactly 1 cycle, starting the edge that samples the last pattern bit.
  - wake_transmitter is high exactly 1 cycle, starting the edge that samples transmitter_signal=1.
- match_count increments by 1 on every HUNT -> RISE_NBIT transition and wraps from 2^CNT_W-1 to 0.
- On every exit from HUNT, sh and fill clear to 0. A new pattern needs PAT_LEN fresh bits after the return to HUNT; serial_in is ignored while busy.
- Overlap within HUNT is handled naturally by the sliding window. Example: with default PATTERN, the stream 0,1,1,1,1,1,1,0 does not match (six ones), and the window slides on.
- timeout_err: set when any timeout occurs, cleared when clr_err=1. If set and clear happen on the same edge, set wins.
- transmitter_signal and get_back are ignored outside their own wait state. A get_back that is already high on entry to WAIT_BACK completes on the first cycle in that state.

Test Plan:
- Default params, rst low 2 cycles, then serial 1,1,0,1,1,1,1,1,0 -> wake_nbit pulses once, 1 cycle, at the edge sampling the final 0. match_count=1, busy=1.
- After detection, transmitter_signal high 3 cycles later -> wake_transmitter 1-cycle pulse. Then get_back=1 -> HUNT, busy=0. The next pattern is detected only after 7 new bits.
- TIMEOUT=4, no transmitter_signal -> after 4 cycles in WAIT_TR: HUNT, timeout_err=1, no wake_transmitter. clr_err pulse -> timeout_err=0. transmitter_signal exactly at the 4th cycle -> success, no error.
- MASK=7'b1000001 with stream 0,0,1,0,1,0,0 -> match (middle bits don't-care). Stream 0,1,1,1,1,1,1,0 with full mask -> no match until a valid pattern follows.
- CNT_W=2, 5 complete transactions -> match_count reads 1,2,3,0,1.
- rst low while in WAIT_BACK -> next edge: HUNT, all outputs 0, match_count 0. serial_in toggling while busy causes no detection.
